// File: rtl/addsub_serial.sv
// Slice-serial adder/subtractor: processes SLICE bits per cycle, LSB slice first,
// with unsigned/signed overflow detection and optional saturation.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             D,
  input  logic             Si,
  input  logic             Cin,
  input  logic             Sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             So,
  output logic             Z
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             carry, d_r, si_r, sat_r;
  logic             last;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] s_raw, sat_val, s_final;
  logic             raw_v;

  assign last = (cnt == CW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // b_sh already holds ~B for subtract, so the slice adder only ever adds.
  always_comb begin
    slice_sum = {1'b0, a_sh[SLICE-1:0]} + {1'b0, b_sh[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
    s_raw = res;
    s_raw[WIDTH-1 -: SLICE] = slice_sum[SLICE-1:0];
    if (si_r)
      raw_v = (a_sh[SLICE-1] == b_sh[SLICE-1]) && (slice_sum[SLICE-1] != a_sh[SLICE-1]);
    else
      raw_v = d_r ? ~slice_sum[SLICE] : slice_sum[SLICE];
    if (!si_r)
      sat_val = d_r ? '0 : '1;
    else if (a_sh[SLICE-1])
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    s_final = (sat_r && raw_v) ? sat_val : s_raw;
  end

  // On the last slice a_sh holds A's top slice, so its MSB is the registered sign of A.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      d_r   <= 1'b0;
      si_r  <= 1'b0;
      sat_r <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
      So    <= 1'b0;
      Z     <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_sh  <= A;
      b_sh  <= D ? ~B : B;
      carry <= D ? 1'b1 : Cin;
      d_r   <= D;
      si_r  <= Si;
      sat_r <= Sat;
      cnt   <= '0;
    end else if (state == BUSY) begin
      a_sh  <= a_sh >> SLICE;
      b_sh  <= b_sh >> SLICE;
      carry <= slice_sum[SLICE];
      res[cnt*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
      cnt   <= cnt + 1'b1;
      if (last) begin
        S    <= s_final;
        Cout <= slice_sum[SLICE];
        V    <= raw_v;
        So   <= s_final[WIDTH-1];
        Z    <= (s_final == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed-vector bench for addsub_serial (WIDTH=32, SLICE=8): arithmetic,
// saturation, latency, back-pressure and mid-operation reset.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] A, B;
  logic        D, Si, Cin, Sat;
  logic        out_valid, out_ready;
  logic [31:0] S;
  logic        Cout, V, So, Z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .D(D), .Si(Si), .Cin(Cin), .Sat(Sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V), .So(So), .Z(Z)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one request and returns #1 after its accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic d,
                               input logic si, input logic cin, input logic sat, input bit hold);
    @(negedge clk);
    A = a; B = b; D = d; Si = si; Cin = cin; Sat = sat;
    in_valid = 1'b1;
    #1;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] s, input logic c,
                             input logic v, input logic so, input logic z);
    checkOutput({tag, "_S"},    S,           s);
    checkOutput({tag, "_Cout"}, 32'(Cout),   32'(c));
    checkOutput({tag, "_V"},    32'(V),      32'(v));
    checkOutput({tag, "_So"},   32'(So),     32'(so));
    checkOutput({tag, "_Z"},    32'(Z),      32'(z));
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic d, input logic si, input logic cin, input logic sat,
                       input logic [31:0] s, input logic c, input logic v,
                       input logic so, input logic z);
    applyStimulus(a, b, d, si, cin, sat, 1'b0);
    waitDone(tag);
    checkResult(tag, s, c, v, so, z);
    releaseResult(tag);
  endtask

  initial begin
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; D = 1'b0; Si = 1'b0; Cin = 1'b0; Sat = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_S",         S,              32'd0);
    checkOutput("rst_flags",     32'({Cout, V, So, Z}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(in_ready), 32'd1);

    runOp("uadd_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 1, 1, 0);
    runOp("uadd_chain",32'h12345678, 32'h0FEDCBA8, 0, 0, 0, 0, 32'h22222220, 0, 0, 0, 0);
    runOp("usub_wrap", 32'h00000000, 32'h0000000F, 1, 0, 0, 0, 32'hFFFFFFF1, 0, 1, 1, 0);
    runOp("usub_sat",  32'h00000000, 32'h0000000F, 1, 0, 0, 1, 32'h00000000, 0, 1, 0, 1);
    runOp("usub_cin",  32'h0000000A, 32'h00000003, 1, 0, 1, 0, 32'h00000007, 1, 0, 0, 0);
    runOp("ssub_ovf",  32'hFFFFFFFE, 32'h7FFFFFFF, 1, 1, 0, 0, 32'h7FFFFFFF, 1, 1, 0, 0);
    runOp("ssub_sat",  32'hFFFFFFFE, 32'h7FFFFFFF, 1, 1, 0, 1, 32'h80000000, 1, 1, 1, 0);
    runOp("sadd_sat",  32'h00000004, 32'h7FFFFFFF, 0, 1, 0, 1, 32'h7FFFFFFF, 0, 1, 0, 0);
    runOp("ssub_zero", 32'h00000005, 32'h00000005, 1, 1, 0, 0, 32'h00000000, 1, 0, 0, 1);

    // A second request stays asserted through BUSY and DONE with different operands.
    applyStimulus(32'h12345678, 32'h0FEDCBA8, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    A = 32'h00000001; B = 32'h00000002;
    waitDone("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkResult("bp_hold", 32'h22222220, 0, 0, 0, 0);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_drop",      32'(out_valid), 32'd0);
    checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_accepted", 32'(in_ready), 32'd0);
    waitDone("bp_next");
    checkResult("bp_next", 32'h00000003, 0, 0, 0, 0);
    releaseResult("bp_next");

    // Reset lands on the second BUSY cycle of an operation.
    applyStimulus(32'h00000005, 32'h00000003, 0, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_S",     S,              32'd0);
    checkOutput("mid_rst_flags", 32'({Cout, V, So, Z}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_release_ready", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    checkOutput("mid_rst_no_stale", 32'(stale), 32'd0);

    runOp("post_rst", 32'h00000001, 32'h00000001, 0, 0, 0, 0, 32'h00000002, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
